// File: rtl/fp_round_norm_if.sv
// rtl/fp_round_norm_if.sv - valid/ready bundle between the significand adder, the round stage and its consumer
interface fp_round_norm_if #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
);
    logic [1:0]              rm;
    logic                    in_valid;
    logic                    in_ready;
    logic [EXP_W-1:0]        in_es;
    logic [FRAC_W+4:0]       in_fs;
    logic                    in_ss;
    logic [1:0]              in_fls;
    logic                    in_nan;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_result;
    logic [3:0]              out_flags;

    modport master (
        output rm, in_valid, in_es, in_fs, in_ss, in_fls, in_nan, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  rm, in_valid, in_es, in_fs, in_ss, in_fls, in_nan, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_round_norm.sv
// rtl/fp_round_norm.sv - binary64 post-adder normalize/round stage; FP_FAST_NORM_EN selects single-cycle normalize
// The packed result is registered on the first DONE cycle and held until the consumer takes it.
module fp_round_norm #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input  logic           clk,
    input  logic           rst,
    fp_round_norm_if.slave bus
);
    localparam int SW = FRAC_W + 5;
    localparam int XW = EXP_W + 2;
    localparam int MW = FRAC_W + 1;
    localparam int RW = EXP_W + FRAC_W + 1;
    localparam logic signed [XW-1:0] ONE     = XW'(1);
    localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;

    typedef enum logic [2:0] {S_IDLE, S_SPECIAL, S_NORM, S_ROUND, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic signed [XW-1:0] r_exp, w_exp_nxt, w_exp_rnd;
    logic [SW-1:0]        r_fs, w_fs_nxt;
    logic                 r_ss, r_nan, r_inf;
    logic [1:0]           r_rm;
    logic [RW-1:0]        r_res, w_res_nxt, r_out_result, w_out_result_nxt;
    logic [3:0]           r_flg, w_flg_nxt, r_out_flags, w_out_flags_nxt;
    logic                 r_out_valid, w_out_valid_nxt;
    logic                 w_accept;
    logic                 w_g, w_s, w_lsb, w_inx, w_inc, w_ovf, w_ovf_to_inf;
    logic [SW-4:0]        w_sum;
    logic [MW-1:0]        w_mant;
    logic [RW-1:0]        w_inf_res, w_max_res, w_rnd_res;

    assign w_accept       = (r_state == S_IDLE) && bus.in_valid;
    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_flags  = r_out_flags;

    assign w_lsb = r_fs[3];
    assign w_g   = r_fs[2];
    assign w_s   = |r_fs[1:0];
    assign w_inx = w_g | w_s;

    always_comb begin
        w_inc        = 1'b0;
        w_ovf_to_inf = 1'b1;
        case (r_rm)
            2'b00: begin w_inc = w_g & (w_s | w_lsb); w_ovf_to_inf = 1'b1;  end
            2'b01: begin w_inc = 1'b0;                w_ovf_to_inf = 1'b0;  end
            2'b10: begin w_inc = ~r_ss & w_inx;       w_ovf_to_inf = ~r_ss; end
            default: begin w_inc = r_ss & w_inx;      w_ovf_to_inf = r_ss;  end
        endcase
    end

    // Normalized input has fs[56]=0, so a set top bit of the sum is exactly the rounding carry.
    assign w_sum     = r_fs[SW-1:3] + {{(SW-4){1'b0}}, w_inc};
    assign w_mant    = w_sum[SW-4] ? w_sum[SW-4:1] : w_sum[SW-5:0];
    assign w_exp_rnd = w_sum[SW-4] ? r_exp + ONE : r_exp;
    assign w_ovf     = (w_exp_rnd >= EXP_TOP);
    assign w_inf_res = {r_ss, EXP_ONES, {FRAC_W{1'b0}}};
    assign w_max_res = {r_ss, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
    assign w_rnd_res = {r_ss, (w_mant[FRAC_W] ? w_exp_rnd[EXP_W-1:0] : {EXP_W{1'b0}}),
                        w_mant[FRAC_W-1:0]};

`ifdef FP_FAST_NORM_EN
    localparam int LZW = $clog2(SW);
    logic [LZW-1:0]       w_lz, w_sh;
    logic signed [XW-1:0] w_room;

    always_comb begin
        w_lz = LZW'(SW - 1);
        for (int i = 0; i < SW - 1; i++) begin
            if (r_fs[i]) w_lz = LZW'(SW - 2 - i);
        end
    end

    // Never shift the exponent below 1; the remainder stays subnormal.
    assign w_room = r_exp - ONE;
    assign w_sh   = (w_room < $signed({{(XW-LZW){1'b0}}, w_lz})) ? w_room[LZW-1:0] : w_lz;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_exp_nxt        = r_exp;
        w_fs_nxt         = r_fs;
        w_res_nxt        = r_res;
        w_flg_nxt        = r_flg;
        w_out_valid_nxt  = r_out_valid;
        w_out_result_nxt = r_out_result;
        w_out_flags_nxt  = r_out_flags;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_exp_nxt   = (bus.in_es == '0) ? ONE : $signed({2'b00, bus.in_es});
                    w_fs_nxt    = bus.in_fs;
                    w_state_nxt = (bus.in_nan || bus.in_fls != 2'b00 || bus.in_fs == '0)
                                  ? S_SPECIAL : S_NORM;
                end
            end
            S_SPECIAL: begin
                w_flg_nxt = 4'b0000;
                if (r_nan) begin
                    w_res_nxt = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
                    w_flg_nxt = 4'b0001;
                end else if (r_inf) begin
                    w_res_nxt = w_inf_res;
                end else begin
                    w_res_nxt = {r_ss, {(RW-1){1'b0}}};
                end
                w_state_nxt = S_DONE;
            end
            S_NORM: begin
                if (r_fs[SW-1]) begin
                    w_fs_nxt    = {1'b0, r_fs[SW-1:2], r_fs[1] | r_fs[0]};
                    w_exp_nxt   = r_exp + ONE;
                    w_state_nxt = S_ROUND;
                end else begin
`ifdef FP_FAST_NORM_EN
                    w_fs_nxt    = r_fs << w_sh;
                    w_exp_nxt   = r_exp - $signed({{(XW-LZW){1'b0}}, w_sh});
                    w_state_nxt = S_ROUND;
`else
                    if (r_fs[SW-2] || r_exp <= ONE) begin
                        w_state_nxt = S_ROUND;
                    end else begin
                        w_fs_nxt  = r_fs << 1;
                        w_exp_nxt = r_exp - ONE;
                        if (r_fs[SW-3] || r_exp == ONE + ONE) w_state_nxt = S_ROUND;
                    end
`endif
                end
            end
            S_ROUND: begin
                if (w_ovf) begin
                    w_res_nxt = w_ovf_to_inf ? w_inf_res : w_max_res;
                    w_flg_nxt = 4'b1010;
                end else begin
                    w_res_nxt = w_rnd_res;
                    w_flg_nxt = {1'b0, ~w_mant[FRAC_W] & w_inx, w_inx, 1'b0};
                end
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!r_out_valid) begin
                    w_out_valid_nxt  = 1'b1;
                    w_out_result_nxt = r_res;
                    w_out_flags_nxt  = r_flg;
                end else if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_exp        <= '0;
            r_fs         <= '0;
            r_ss         <= 1'b0;
            r_nan        <= 1'b0;
            r_inf        <= 1'b0;
            r_rm         <= 2'b00;
            r_res        <= '0;
            r_flg        <= 4'b0000;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= 4'b0000;
        end else begin
            r_state      <= w_state_nxt;
            r_exp        <= w_exp_nxt;
            r_fs         <= w_fs_nxt;
            r_res        <= w_res_nxt;
            r_flg        <= w_flg_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_result <= w_out_result_nxt;
            r_out_flags  <= w_out_flags_nxt;
            if (w_accept) begin
                r_ss  <= bus.in_ss;
                r_nan <= bus.in_nan;
                r_inf <= bus.in_fls[1];
                r_rm  <= bus.rm;
            end
        end
    end
endmodule

// File: tb/tb_fp_round_norm.sv
// tb/tb_fp_round_norm.sv - directed scoreboard bench for fp_round_norm
module tb_fp_round_norm;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [67:0] sb_q[$];

    fp_round_norm_if bus ();

    fp_round_norm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef FP_FAST_NORM_EN
    localparam int CANCEL_LAT = 3;
    localparam int CLAMP_LAT  = 3;
`else
    localparam int CANCEL_LAT = 12;
    localparam int CLAMP_LAT  = 6;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [1:0] rmv, input logic [10:0] es, input logic [56:0] fs,
                         input logic ss, input logic [1:0] fls, input logic nan);
        bus.rm       = rmv;
        bus.in_es    = es;
        bus.in_fs    = fs;
        bus.in_ss    = ss;
        bus.in_fls   = fls;
        bus.in_nan   = nan;
        bus.in_valid = 1'b1;
    endtask

    task automatic txn(input string tag, input logic [1:0] rmv, input logic [10:0] es,
                       input logic [56:0] fs, input logic ss, input logic [1:0] fls, input logic nan,
                       input logic [63:0] er, input logic [3:0] ef, input int lat, input int hold);
        logic [67:0] e;
        int n;
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        drive(rmv, es, fs, ss, fls, nan);
        sb_q.push_back({er, ef});
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(lat));
        e = sb_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, ".hold_result"}, bus.out_result, e[67:4]);
            chk({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        chk({tag, ".result"}, bus.out_result, e[67:4]);
        chk({tag, ".flags"}, 64'(bus.out_flags), 64'(e[3:0]));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.rm        = 2'b00;
        bus.in_valid  = 1'b0;
        bus.in_es     = '0;
        bus.in_fs     = '0;
        bus.in_ss     = 1'b0;
        bus.in_fls    = 2'b00;
        bus.in_nan    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset.out_result", bus.out_result, 64'd0);
        chk("reset.out_flags", 64'(bus.out_flags), 64'd0);
        rst = 1'b0;

        txn("carry_in", 2'b00, 11'h3FF, 57'd1 << 56, 1'b0, 2'b00, 1'b0,
            64'h4000000000000000, 4'b0000, 3, 0);
        txn("rne_up", 2'b00, 11'h3FF, (57'd1 << 55) | (57'd1 << 3) | (57'd1 << 2), 1'b0, 2'b00, 1'b0,
            64'h3FF0000000000002, 4'b0010, 3, 0);
        txn("rz_trunc", 2'b01, 11'h3FF, (57'd1 << 55) | (57'd1 << 3) | (57'd1 << 2), 1'b0, 2'b00, 1'b0,
            64'h3FF0000000000001, 4'b0010, 3, 0);
        txn("cancel", 2'b00, 11'h3FF, 57'd1 << 45, 1'b0, 2'b00, 1'b0,
            64'h3F50000000000000, 4'b0000, CANCEL_LAT, 0);
        txn("ovf_rne", 2'b00, 11'h7FE, 57'd1 << 56, 1'b0, 2'b00, 1'b0,
            64'h7FF0000000000000, 4'b1010, 3, 0);
        txn("ovf_rz", 2'b01, 11'h7FE, 57'd1 << 56, 1'b0, 2'b00, 1'b0,
            64'h7FEFFFFFFFFFFFFF, 4'b1010, 3, 0);
        txn("ovf_up_neg", 2'b10, 11'h7FE, 57'd1 << 56, 1'b1, 2'b00, 1'b0,
            64'hFFEFFFFFFFFFFFFF, 4'b1010, 3, 0);
        txn("ovf_dn_neg", 2'b11, 11'h7FE, 57'd1 << 56, 1'b1, 2'b00, 1'b0,
            64'hFFF0000000000000, 4'b1010, 3, 0);
        txn("inf_hold", 2'b00, 11'h3FF, 57'd1 << 55, 1'b1, 2'b10, 1'b0,
            64'hFFF0000000000000, 4'b0000, 2, 5);
        txn("nan", 2'b00, 11'h3FF, 57'd1 << 55, 1'b0, 2'b00, 1'b1,
            64'h7FF8000000000000, 4'b0001, 2, 0);
        txn("zero_neg", 2'b00, 11'h3FF, 57'd0, 1'b1, 2'b00, 1'b0,
            64'h8000000000000000, 4'b0000, 2, 0);
        txn("subnormal", 2'b00, 11'h001, (57'd1 << 50) | 57'd1, 1'b0, 2'b00, 1'b0,
            64'h0000800000000000, 4'b0110, 3, 0);
        txn("round_carry", 2'b00, 11'h3FF, {2'b01, {52{1'b1}}, 3'b100}, 1'b0, 2'b00, 1'b0,
            64'h4000000000000000, 4'b0010, 3, 0);
        txn("up_pos", 2'b10, 11'h3FF, (57'd1 << 55) | 57'd1, 1'b0, 2'b00, 1'b0,
            64'h3FF0000000000001, 4'b0010, 3, 0);
        txn("sub_to_norm", 2'b00, 11'h000, {2'b00, {52{1'b1}}, 3'b100}, 1'b0, 2'b00, 1'b0,
            64'h0010000000000000, 4'b0010, 3, 0);
        txn("norm_clamp", 2'b00, 11'h005, 57'd1 << 45, 1'b0, 2'b00, 1'b0,
            64'h0000400000000000, 4'b0000, CLAMP_LAT, 0);

        @(negedge clk);
        drive(2'b00, 11'h3FF, 57'd1 << 45, 1'b0, 2'b00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid.out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) n++;
        end
        chk("rst_mid.no_output", 64'(n), 64'd0);

        txn("after_rst", 2'b00, 11'h3FF, 57'd1 << 56, 1'b0, 2'b00, 1'b0,
            64'h4000000000000000, 4'b0000, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
